serial_adder_subtractor: RTL and testbench

- Bit-serial adder/subtractor for WIDTH-bit operands.
- Operands are loaded in parallel on a start handshake, then processed LSB first through a single full-adder stage (sum = a^b^c, carry = majority) with a registered carry, one bit per clock.
- The result is collected in a shift register and presented with a one-cycle done pulse.
- Sits downstream of the one-bit full-adder stage and sequences it across a word; it is the word-level consumer of that stage's sum/carry outputs.

---
 rtl/serial_adder_subtractor.sv | 111 +++++++++++
 tb/tb_serial_adder_subtractor.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_subtractor.sv
// Bit-serial adder/subtractor: one full-adder stage with a registered carry
// walks the operands LSB first, one bit per clock, and pulses done at the end.
module serial_adder_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opb_q, sr_q, result_q;
  logic [CNT_W-1:0] count_q;
  logic             carry_q, carry_out_q, overflow_q;
  logic             s_bit, c_bit, accept, last_bit;

  // ---------------------------------------------------------------- FSM
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: state_d is defaulted first so no path through the case leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (count_q == LAST_BIT) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      SHIFT:   busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // ------------------------------------------------------------ datapath
  assign accept   = (state_q == IDLE) && start;
  assign last_bit = (state_q == SHIFT) && (count_q == LAST_BIT);

  // Single full-adder stage; carry_q is the carry into the current bit.
  always_comb begin
    s_bit = opa_q[0] ^ opb_q[0] ^ carry_q;
    c_bit = (opa_q[0] & opb_q[0]) | (opa_q[0] & carry_q) | (opb_q[0] & carry_q);
  end

  // NOTE: every register, including the shift registers, is reset so an
  // aborted operation leaves no stale partial state behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opa_q       <= '0;
      opb_q       <= '0;
      sr_q        <= '0;
      carry_q     <= 1'b0;
      count_q     <= '0;
      result_q    <= '0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else if (accept) begin
      // Subtraction is a + ~b + 1: the +1 enters as the initial carry.
      opa_q   <= a;
      opb_q   <= sub ? ~b : b;
      carry_q <= sub;
      count_q <= '0;
    end else if (state_q == SHIFT) begin
      sr_q    <= {s_bit, sr_q[WIDTH-1:1]};
      opa_q   <= opa_q >> 1;
      opb_q   <= opb_q >> 1;
      carry_q <= c_bit;
      count_q <= count_q + CNT_W'(1);
      if (last_bit) begin
        // Published outputs only move here, so they hold between operations.
        result_q    <= {s_bit, sr_q[WIDTH-1:1]};
        carry_out_q <= c_bit;
        overflow_q  <= carry_q ^ c_bit;
      end
    end
  end

  assign result    = result_q;
  assign carry_out = carry_out_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_serial_adder_subtractor.sv
// Scoreboard bench: directed WIDTH=8 vectors plus an exhaustive WIDTH=3 sweep.
module tb_serial_adder_subtractor;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic         start8, sub8, busy8, done8, cout8, ovf8;
  logic [W-1:0] a8, b8, result8;
  logic         start3, sub3, busy3, done3, cout3, ovf3;
  logic [2:0]   a3, b3, result3;

  serial_adder_subtractor #(.WIDTH(W)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .sub(sub8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .result(result8), .carry_out(cout8), .overflow(ovf8)
  );

  serial_adder_subtractor #(.WIDTH(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .sub(sub3), .a(a3), .b(b3),
    .busy(busy3), .done(done3), .result(result3), .carry_out(cout3), .overflow(ovf3)
  );

  typedef struct packed {
    logic [7:0] r;
    logic       c;
    logic       v;
  } exp_t;

  exp_t q8[$];
  exp_t q3[$];
  exp_t e8, e3;
  int   errors = 0;
  int   checks = 0;
  int   done_cnt8 = 0;
  logic prev_done8 = 1'b0;
  logic prev_done3 = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitors: pop the expected response whenever a done pulse is seen.
  always @(negedge clk) begin
    if (done8 === 1'b1) begin
      done_cnt8++;
      check("done8_width", 32'(prev_done8), 32'd0);
      if (q8.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL done8_unexpected: got done with empty scoreboard at %0t", $time);
      end else begin
        e8 = q8.pop_front();
        check("result8", 32'(result8), 32'(e8.r));
        check("carry8", 32'(cout8), 32'(e8.c));
        check("ovf8", 32'(ovf8), 32'(e8.v));
      end
    end
    prev_done8 = done8;
  end

  always @(negedge clk) begin
    if (done3 === 1'b1) begin
      check("done3_width", 32'(prev_done3), 32'd0);
      if (q3.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL done3_unexpected: got done with empty scoreboard at %0t", $time);
      end else begin
        e3 = q3.pop_front();
        check("result3", 32'(result3), 32'(e3.r));
        check("carry3", 32'(cout3), 32'(e3.c));
        check("ovf3", 32'(ovf3), 32'(e3.v));
      end
    end
    prev_done3 = done3;
  end

  // One WIDTH=8 operation; optionally pulses start again at poke_cycle while busy.
  task automatic run8(input logic s, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] r, input logic c, input logic v, input int poke_cycle);
    int cyc;
    @(negedge clk);
    start8 = 1'b1; sub8 = s; a8 = a; b8 = b;
    q8.push_back('{r: r, c: c, v: v});
    @(negedge clk);
    start8 = 1'b0;
    cyc = 1;
    check("busy8_after_accept", 32'(busy8), 32'd1);
    // Operand changes while busy must not matter.
    a8 = 8'hAA; b8 = 8'h55; sub8 = ~s;
    while (done8 !== 1'b1 && cyc < 40) begin
      start8 = (cyc == poke_cycle);
      if (cyc == poke_cycle) a8 = 8'hFF;
      @(negedge clk);
      cyc++;
    end
    start8 = 1'b0;
    check("latency8", 32'(cyc), 32'(W + 1));
    check("busy8_at_done", 32'(busy8), 32'd0);
    @(negedge clk);
    check("done8_one_cycle", 32'(done8), 32'd0);
    check("result8_hold", 32'(result8), 32'(r));
  endtask

  initial begin : watchdog
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int cyc, first_done;
    logic [2:0] ab, bb, r3;
    int ia, ib, res;
    logic c3, v3;

    rst_n = 1'b0;
    start8 = 1'b0; sub8 = 1'b0; a8 = '0; b8 = '0;
    start3 = 1'b0; sub3 = 1'b0; a3 = '0; b3 = '0;
    #1;
    check("rst_busy", 32'(busy8), 32'd0);
    check("rst_done", 32'(done8), 32'd0);
    check("rst_result", 32'(result8), 32'd0);
    check("rst_carry", 32'(cout8), 32'd0);
    check("rst_ovf", 32'(ovf8), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors with hand-computed results.
    run8(1'b0, 8'h25, 8'h3C, 8'h61, 1'b0, 1'b0, -1);
    run8(1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, -1);
    run8(1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, -1);
    run8(1'b1, 8'h10, 8'h20, 8'hF0, 1'b0, 1'b0, -1);
    run8(1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1, -1);
    run8(1'b0, 8'h01, 8'h01, 8'h02, 1'b0, 1'b0, 3);

    // start held high: back-to-back operations every W+2 cycles.
    @(negedge clk);
    start8 = 1'b1; sub8 = 1'b0; a8 = 8'h03; b8 = 8'h04;
    q8.push_back('{r: 8'h07, c: 1'b0, v: 1'b0});
    q8.push_back('{r: 8'h30, c: 1'b0, v: 1'b0});
    @(negedge clk);
    a8 = 8'h10; b8 = 8'h20;
    cyc = 1;
    first_done = -1;
    while (cyc < 60) begin
      if (done8 === 1'b1) begin
        if (first_done < 0) first_done = cyc;
        else break;
      end
      @(negedge clk);
      cyc++;
    end
    start8 = 1'b0;
    check("b2b_first_latency", 32'(first_done), 32'(W + 1));
    check("b2b_spacing", 32'(cyc - first_done), 32'(W + 2));
    repeat (2) @(negedge clk);

    // Reset mid-operation aborts immediately.
    start8 = 1'b1; a8 = 8'h11; b8 = 8'h22; sub8 = 1'b0;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy8), 32'd0);
    check("abort_done", 32'(done8), 32'd0);
    check("abort_result", 32'(result8), 32'd0);
    check("abort_carry", 32'(cout8), 32'd0);
    check("abort_ovf", 32'(ovf8), 32'd0);
    cyc = done_cnt8;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("abort_no_done", 32'(done_cnt8), 32'(cyc));
    check("abort_idle", 32'(busy8), 32'd0);

    // Exhaustive WIDTH=3 sweep against signed/unsigned integer arithmetic.
    for (int s = 0; s < 2; s++) begin
      for (int ai = 0; ai < 8; ai++) begin
        for (int bi = 0; bi < 8; bi++) begin
          ab = 3'(ai);
          bb = 3'(bi);
          ia = ab[2] ? ai - 8 : ai;
          ib = bb[2] ? bi - 8 : bi;
          if (s == 1) begin
            res = ia - ib;
            r3  = 3'(ai - bi);
            c3  = (ai >= bi);
          end else begin
            res = ia + ib;
            r3  = 3'(ai + bi);
            c3  = (ai + bi) > 7;
          end
          v3 = (res < -4) || (res > 3);
          @(negedge clk);
          start3 = 1'b1; sub3 = (s == 1); a3 = ab; b3 = bb;
          q3.push_back('{r: {5'b0, r3}, c: c3, v: v3});
          @(negedge clk);
          start3 = 1'b0;
          cyc = 1;
          while (done3 !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
          end
          if (done3 !== 1'b1) check("w3_timeout", 32'(cyc), 32'd4);
          @(negedge clk);
        end
      end
    end
    repeat (3) @(negedge clk);
    check("q8_drained", 32'(q8.size()), 32'd0);
    check("q3_drained", 32'(q3.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
